// File: rtl/mux_serializer_if.sv
// Handshake bus between the serializer, its upstream word source and the downstream bit consumer.
interface mux_serializer_if;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned SEL_W  = 3;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic [SEL_W-1:0]  out_sel;
   logic              out_bit;
   logic              out_valid;
   logic              out_last;
   logic              out_ready;
   logic              busy;

   modport master (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_bit, out_valid, out_last, busy
   );

   modport slave (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_bit, out_valid, out_last, busy
   );
endinterface

// File: rtl/mux_serializer_ctrl.sv
// Word-to-bit serializer driving the data and select inputs of the 8:1 mux stage,
// with valid/last framing, downstream stall and an optional idle gap between words.
module mux_serializer_ctrl #(
   parameter bit          MSB_FIRST  = 1'b0,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   mux_serializer_if.master  bus
);
   localparam int unsigned DATA_W = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned GAP_W  = 8;

   localparam logic [SEL_W-1:0] FIRST_SEL = MSB_FIRST ? SEL_W'(7) : SEL_W'(0);
   localparam logic [SEL_W-1:0] LAST_SEL  = MSB_FIRST ? SEL_W'(0) : SEL_W'(7);
   localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? GAP_W'(0) : GAP_W'(GAP_CYCLES - 1);
   localparam bit               HAS_GAP   = (GAP_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  data_q, data_nxt;
   logic [SEL_W-1:0]   sel_q, sel_nxt;
   logic [GAP_W-1:0]   gap_q, gap_nxt;
   logic               valid_q, valid_nxt;
   logic               last_q, last_nxt;
   logic               busy_q, busy_nxt;

   // State and registered framing outputs; reset discards any in-flight word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         data_q  <= '0;
         sel_q   <= '0;
         gap_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         data_q  <= data_nxt;
         sel_q   <= sel_nxt;
         gap_q   <= gap_nxt;
         valid_q <= valid_nxt;
         last_q  <= last_nxt;
         busy_q  <= busy_nxt;
      end
   end

   // Next-state; framing flags are precomputed from the next state so they register cleanly.
   always_comb begin
      state_nxt = state;
      data_nxt  = data_q;
      sel_nxt   = sel_q;
      gap_nxt   = gap_q;

      unique case (state)
         IDLE: begin
            if (bus.in_valid) begin
               data_nxt  = bus.in_data;
               sel_nxt   = FIRST_SEL;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (bus.out_ready) begin
               if (sel_q == LAST_SEL) begin
                  if (HAS_GAP) begin
                     state_nxt = GAP;
                     gap_nxt   = GAP_LOAD;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  sel_nxt = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
               end
            end
         end
         GAP: begin
            if (gap_q == '0) state_nxt = IDLE;
            else             gap_nxt   = gap_q - GAP_W'(1);
         end
         default: state_nxt = IDLE;
      endcase

      valid_nxt = (state_nxt == SEND);
      last_nxt  = (state_nxt == SEND) && (sel_nxt == LAST_SEL);
      busy_nxt  = (state_nxt != IDLE);
   end

   // in_ready is gated by rst so a handshake can never look accepted in a reset cycle.
   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
   assign bus.out_valid = valid_q;
   assign bus.out_last  = last_q;
   assign bus.busy      = busy_q;
   assign bus.out_bit   = valid_q & data_q[sel_q];
endmodule

// File: doc/mux_serializer_ctrl.md
# mux_serializer_ctrl

Parallel-to-serial front end for the 8:1 multiplexer stage. Accepts an 8-bit word over a valid/ready handshake, holds it on the mux data bus and steps the 3-bit select through all eight positions, one bit per accepted output beat. It presents the selected bit with valid/last framing to a downstream consumer that can stall. It sits directly upstream of the 8:1 mux: `out_data` drives the mux data inputs, `out_sel` drives the mux select, and `out_bit` equals the mux output.

## Interface
- `MSB_FIRST`, default 0: 0 sends bit 0 first (sel 0→7); 1 sends bit 7 first (sel 7→0).
- `GAP_CYCLES`, default 0: idle cycles inserted after each word before the next is accepted. Range 0..255.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  word to serialize; sampled on the handshake.
- `in_valid`  in  1  upstream has a word.
- `in_ready`  out  1  block can accept a word.
- `out_data`  out  8  held word; feeds the mux data inputs.
- `out_sel`  out  3  current bit index; feeds the mux select.
- `out_bit`  out  1  `out_data[out_sel]` while `out_valid`, else 0.
- `out_valid`  out  1  `out_bit` is a valid beat.
- `out_last`  out  1  current beat is the 8th bit of the word.
- `out_ready`  in  1  downstream accepts the beat.
- `busy`  out  1  high in SEND or GAP.

## Operation
- States: IDLE, SEND, GAP.
- IDLE
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`: register `in_data` into `out_data`; set `out_sel` to 7 if `MSB_FIRST`, else 0; go to SEND.
- SEND
  - `out_valid`=1 and `in_ready`=0.
  - `out_bit` is combinational from registered `out_data` and `out_sel`.
  - Beat accepted when `out_valid && out_ready`: `out_sel` increments (LSB-first) or decrements (MSB-first), 3-bit wrap-free within the word.
  - `out_last`=1 when `out_sel` is 7 (LSB-first) or 0 (MSB-first).
  - Accepted last beat: go to GAP if `GAP_CYCLES`>0, else IDLE.
- GAP
  - Counter loads `GAP_CYCLES`-1 and decrements each cycle.
  - Outputs are `in_ready`=0, `out_valid`=0.
  - At 0, go to IDLE.
- Stall: with `out_ready`=0 in SEND, `out_sel`, `out_data`, `out_bit` and `out_last` hold unchanged indefinitely.
- `out_data` holds the last word after SEND until the next capture; it is not cleared.
- `in_data` changes outside the handshake are ignored.
- Reset (any state, including mid-word or mid-gap) takes effect on the next edge and discards the in-flight word. Reset values:
  - `out_data`=0.
  - `out_sel`=0, regardless of `MSB_FIRST`.
  - `out_valid`=0, `out_last`=0, `out_bit`=0, `busy`=0.
  - `in_ready`=0 while `rst` is high; 1 on the first cycle after release.
  - State is IDLE.

## Timing
- Capture at edge k; first beat valid in cycle k+1. No combinational path from `in_valid` to `out_valid`.
- With `out_ready` held high, beats occupy cycles k+1..k+8, and `out_last` is high in cycle k+8.
- GAP covers cycles k+9..k+8+`GAP_CYCLES`. IDLE (`in_ready`=1) follows in cycle k+9+`GAP_CYCLES`.
- Minimum word period is 9+`GAP_CYCLES` cycles.
- `in_ready` depends only on state, never on `in_valid`.
- `out_valid` depends only on state, never on `out_ready`.
- Each stalled cycle extends the word by one cycle.
- Simultaneous `rst` and handshake: reset wins, and the word is not captured.

## Test plan
- Reset then idle:
  - hold `rst` 3 cycles, then release → all outputs 0 during reset;
  - `in_ready`=1 and `busy`=0 from the first post-reset cycle.
- LSB-first, no stall: `in_data`=0xA5, `out_ready`=1 → `out_sel` 0..7 and `out_bit` sequence 1,0,1,0,0,1,0,1 in cycles k+1..k+8. `out_last` only at sel 7; `in_ready` back at k+9.
- MSB-first (`MSB_FIRST`=1), `in_data`=0x3C → `out_sel` 7..0 and bits 0,0,1,1,1,1,0,0; `out_last` at sel 0.
- Stall: 0xF0, `out_ready` low for 4 cycles at beat 3 → sel, bit and last held for those 4 cycles; 8 beats total with no duplicate or skipped index; word completes at k+12.
- Gap and back-to-back: `GAP_CYCLES`=3, `in_valid` held high with words 0x01, 0x80 → second capture exactly 12 cycles after the first; `in_ready`=0 throughout SEND and GAP.
- Reset mid-word: assert `rst` at beat 4 of 0xFF → next cycle shows IDLE values; the next word 0x00 serializes cleanly from sel 0.
